uart_rx_param: RTL and testbench

- Parametrised UART receiver: next generation of the team's fixed 8N1 receiver.
- Configurable data width, parity and stop-bit count; input synchroniser; 3-sample majority vote per bit; false-start rejection; parity, framing and overrun flags.
- Sits behind the shared baud generator, which supplies a `clken` pulse at OVERSAMPLE x baud. Feeds a host/register interface through a sticky `rdy`/`rdy_clr` handshake.

---
 rtl/uart_rx_param.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with majority vote and error flags
//
// Receives asynchronous serial frames (start, DATA_BITS LSB first, optional
// parity, STOP_BITS stop bits) using a clken tick at OVERSAMPLE x baud.
//
// Ports:
//   clk_50m    in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   clken      in   oversample tick, one clk_50m cycle wide
//   rx         in   asynchronous serial line, idle high
//   rdy_clr    in   host acknowledge, clears rdy and overrun
//   data       out  last received payload
//   rdy        out  sticky frame-complete flag
//   parity_err out  parity mismatch in last frame (0 when PARITY = 0)
//   frame_err  out  a checked stop bit was low in last frame
//   overrun    out  sticky: frame completed while rdy was still set
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    input  logic                 clken,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rdy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE - 3);
    localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE - 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          bit_idx;
    logic                   stop_idx;
    logic                   rx_m;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   samp0;
    logic                   samp1;
    logic [DATA_BITS-1:0]   scratch;
    logic                   par_bad;
    logic                   stop_bad;

    logic bit_val;
    logic bit_end;
    logic par_x;

    // Third vote is the live synchronised sample on the deciding tick.
    assign bit_val = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
    assign bit_end = (cnt == CNT_LAST);
    assign par_x   = (^scratch) ^ bit_val;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            samp0      <= 1'b0;
            samp1      <= 1'b0;
            scratch    <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            data       <= '0;
            rdy        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;

            // Acknowledge first; a completion later in this block overrides rdy.
            if (rdy_clr) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end

            if (clken) begin
                // Tracking the previous tick's level makes IDLE wait for a real
                // falling edge, so a held-low break produces only one frame.
                rx_prev <= rx_s;

                case (state)
                    IDLE: begin
                        if (!rx_s && rx_prev) begin
                            state <= START;
                            cnt   <= '0;
                        end
                    end

                    START: begin
                        if (cnt == CNT_MID) begin
                            cnt <= '0;
                            if (rx_s) begin
                                state <= IDLE;
                            end else begin
                                state    <= DATA;
                                bit_idx  <= '0;
                                stop_idx <= 1'b0;
                                par_bad  <= 1'b0;
                                stop_bad <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    DATA, PAR, STOP: begin
                        cnt <= bit_end ? '0 : cnt + 1'b1;
                        if (cnt == CNT_S0) samp0 <= rx_s;
                        if (cnt == CNT_S1) samp1 <= rx_s;

                        if (bit_end) begin
                            case (state)
                                DATA: begin
                                    scratch <= {bit_val, scratch[DATA_BITS-1:1]};
                                    if (bit_idx == IDX_LAST) begin
                                        bit_idx <= '0;
                                        state   <= (PARITY != 0) ? PAR : STOP;
                                    end else begin
                                        bit_idx <= bit_idx + 1'b1;
                                    end
                                end

                                PAR: begin
                                    par_bad <= (PARITY == 1) ? ~par_x : par_x;
                                    state   <= STOP;
                                end

                                default: begin
                                    if (STOP_BITS == 1 || stop_idx) begin
                                        // Frame complete at mid last stop bit.
                                        state      <= IDLE;
                                        stop_idx   <= 1'b0;
                                        data       <= scratch;
                                        parity_err <= (PARITY != 0) && par_bad;
                                        frame_err  <= stop_bad | ~bit_val;
                                        rdy        <= 1'b1;
                                        if (rdy && !rdy_clr) overrun <= 1'b1;
                                    end else begin
                                        stop_bad <= ~bit_val;
                                        stop_idx <= 1'b1;
                                    end
                                end
                            endcase
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard testbench for uart_rx_param
module tb_uart_rx_param;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    logic       clk_50m = 1'b0;
    logic       rst;
    logic       clken;
    logic       rx      [3];
    logic       rdy_clr [3];
    logic       rdy     [3];
    logic       pe      [3];
    logic       fe      [3];
    logic       ov      [3];
    logic [7:0] data0;
    logic [7:0] data1;
    logic [6:0] data2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rise0  = -1;
    int t0     = 0;

    always #10 clk_50m = ~clk_50m;
    always @(posedge clk_50m) cyc <= cyc + 1;

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk_50m(clk_50m), .rst(rst), .clken(clken), .rx(rx[0]), .rdy_clr(rdy_clr[0]),
        .data(data0), .rdy(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0])
    );

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk_50m(clk_50m), .rst(rst), .clken(clken), .rx(rx[1]), .rdy_clr(rdy_clr[1]),
        .data(data1), .rdy(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1])
    );

    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk_50m(clk_50m), .rst(rst), .clken(clken), .rx(rx[2]), .rdy_clr(rdy_clr[2]),
        .data(data2), .rdy(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [8:0] d, input logic p, input logic f, input logic o);
        exp_t e;
        e.d  = d;
        e.pe = p;
        e.fe = f;
        e.ov = o;
        return e;
    endfunction

    task automatic mon_cmp(input int u, input exp_t e, input logic [8:0] d);
        check($sformatf("u%0d data", u), {23'd0, d}, {23'd0, e.d});
        check($sformatf("u%0d rdy", u), {31'd0, rdy[u]}, 32'd1);
        check($sformatf("u%0d parity_err", u), {31'd0, pe[u]}, {31'd0, e.pe});
        check($sformatf("u%0d frame_err", u), {31'd0, fe[u]}, {31'd0, e.fe});
        check($sformatf("u%0d overrun", u), {31'd0, ov[u]}, {31'd0, e.ov});
    endtask

    task automatic unexpected(input int u, input logic [8:0] d);
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL u%0d unexpected frame: data %0h with nothing expected", u, d);
    endtask

    // Monitor: fires on a rising rdy or rising overrun of any instance.
    initial begin : monitor
        logic rq [3];
        logic oq [3];
        for (int i = 0; i < 3; i++) begin
            rq[i] = 1'b0;
            oq[i] = 1'b0;
        end
        forever begin
            @(negedge clk_50m);
            for (int u = 0; u < 3; u++) begin
                if ((rdy[u] === 1'b1 && !rq[u]) || (ov[u] === 1'b1 && !oq[u])) begin
                    case (u)
                        0: begin
                            rise0 = cyc;
                            if (q0.size() == 0) unexpected(0, {1'b0, data0});
                            else mon_cmp(0, q0.pop_front(), {1'b0, data0});
                        end
                        1: begin
                            if (q1.size() == 0) unexpected(1, {1'b0, data1});
                            else mon_cmp(1, q1.pop_front(), {1'b0, data1});
                        end
                        default: begin
                            if (q2.size() == 0) unexpected(2, {2'b0, data2});
                            else mon_cmp(2, q2.pop_front(), {2'b0, data2});
                        end
                    endcase
                end
                rq[u] = (rdy[u] === 1'b1);
                oq[u] = (ov[u] === 1'b1);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic pulse_clr(input int u);
        @(negedge clk_50m);
        rdy_clr[u] = 1'b1;
        @(negedge clk_50m);
        rdy_clr[u] = 1'b0;
        idle(2);
    endtask

    task automatic do_abort(input int u);
        #2 rst = 1'b1;
        #1;
        check("rst data", {24'd0, data0}, 32'd0);
        check("rst rdy", {31'd0, rdy[0]}, 32'd0);
        check("rst parity_err", {31'd0, pe[0]}, 32'd0);
        check("rst frame_err", {31'd0, fe[0]}, 32'd0);
        check("rst overrun", {31'd0, ov[0]}, 32'd0);
        idle(3);
        rst        = 1'b0;
        rx[u]      = 1'b1;
        rdy_clr[u] = 1'b0;
    endtask

    // One bit period is 16 ticks; cycle c of the frame is driven at a negedge.
    task automatic send_frame(input int u, input logic [8:0] d, input int nd,
                              input int has_par, input logic pbit,
                              input logic [1:0] stops, input int nstop,
                              input int glitch = -1, input int clr_at = -1,
                              input int abort_at = -1);
        logic [15:0] fb;
        int          nb;
        fb = '0;
        nb = 1;
        for (int i = 0; i < nd; i++) begin
            fb[nb] = d[i];
            nb = nb + 1;
        end
        if (has_par != 0) begin
            fb[nb] = pbit;
            nb = nb + 1;
        end
        for (int i = 0; i < nstop; i++) begin
            fb[nb] = stops[i];
            nb = nb + 1;
        end
        for (int b = 0; b < nb; b++) begin
            for (int s = 0; s < 16; s++) begin
                @(negedge clk_50m);
                if (b * 16 + s == 0) t0 = cyc;
                if (b * 16 + s == abort_at) begin
                    do_abort(u);
                    return;
                end
                rx[u]      = fb[b] ^ (b * 16 + s == glitch);
                rdy_clr[u] = (b * 16 + s == clr_at);
            end
        end
        @(negedge clk_50m);
        rx[u]      = 1'b1;
        rdy_clr[u] = 1'b0;
        idle(16);
    endtask

    initial begin : stimulus
        rst   = 1'b1;
        clken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx[i]      = 1'b1;
            rdy_clr[i] = 1'b0;
        end
        #1;
        check("reset u0 data", {24'd0, data0}, 32'd0);
        check("reset u0 rdy", {31'd0, rdy[0]}, 32'd0);
        check("reset u0 overrun", {31'd0, ov[0]}, 32'd0);
        check("reset u1 parity_err", {31'd0, pe[1]}, 32'd0);
        check("reset u2 frame_err", {31'd0, fe[2]}, 32'd0);
        idle(4);
        rst = 1'b0;
        idle(40);

        // Basic frame and latency: last stop bit decided 155 cycles after drive.
        q0.push_back(mk(9'hA5, 1'b0, 1'b0, 1'b0));
        send_frame(0, 9'hA5, 8, 0, 1'b0, 2'b01, 1);
        check("u0 latency", rise0 - t0, 32'd155);
        pulse_clr(0);

        // Short low glitch is a false start.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_50m);
            rx[0] = 1'b0;
        end
        @(negedge clk_50m);
        rx[0] = 1'b1;
        idle(80);
        check("u0 glitch no rdy", {31'd0, rdy[0]}, 32'd0);
        q0.push_back(mk(9'h3C, 1'b0, 1'b0, 1'b0));
        send_frame(0, 9'h3C, 8, 0, 1'b0, 2'b01, 1);
        pulse_clr(0);

        // Overrun, clear, and acknowledge coinciding with completion.
        q0.push_back(mk(9'h11, 1'b0, 1'b0, 1'b0));
        send_frame(0, 9'h11, 8, 0, 1'b0, 2'b01, 1);
        q0.push_back(mk(9'h22, 1'b0, 1'b0, 1'b1));
        send_frame(0, 9'h22, 8, 0, 1'b0, 2'b01, 1);
        pulse_clr(0);
        check("u0 clr rdy", {31'd0, rdy[0]}, 32'd0);
        check("u0 clr overrun", {31'd0, ov[0]}, 32'd0);
        check("u0 clr keeps data", {24'd0, data0}, 32'h22);
        q0.push_back(mk(9'h33, 1'b0, 1'b0, 1'b0));
        send_frame(0, 9'h33, 8, 0, 1'b0, 2'b01, 1);
        send_frame(0, 9'h44, 8, 0, 1'b0, 2'b01, 1, -1, 154);
        check("u0 coincide data", {24'd0, data0}, 32'h44);
        check("u0 coincide rdy", {31'd0, rdy[0]}, 32'd1);
        check("u0 coincide overrun", {31'd0, ov[0]}, 32'd0);
        pulse_clr(0);

        // Single-tick glitch on the middle vote of data bit 3.
        q0.push_back(mk(9'h00, 1'b0, 1'b0, 1'b0));
        send_frame(0, 9'h00, 8, 0, 1'b0, 2'b01, 1, 71);
        pulse_clr(0);

        // Reset during data bit 4, then a clean frame.
        q0.push_back(mk(9'h5A, 1'b0, 1'b0, 1'b0));
        send_frame(0, 9'h5A, 8, 0, 1'b0, 2'b01, 1);
        send_frame(0, 9'hFF, 8, 0, 1'b0, 2'b01, 1, -1, -1, 88);
        idle(40);
        q0.push_back(mk(9'hC3, 1'b0, 1'b0, 1'b0));
        send_frame(0, 9'hC3, 8, 0, 1'b0, 2'b01, 1);
        pulse_clr(0);

        // Break: exactly one frame with data 0 and framing error.
        q0.push_back(mk(9'h00, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 15 * 16; i++) begin
            @(negedge clk_50m);
            rx[0] = 1'b0;
        end
        @(negedge clk_50m);
        rx[0] = 1'b1;
        idle(40);
        pulse_clr(0);
        q0.push_back(mk(9'h69, 1'b0, 1'b0, 1'b0));
        send_frame(0, 9'h69, 8, 0, 1'b0, 2'b01, 1);
        pulse_clr(0);

        // Even parity: 0x37 has five ones, so the correct parity bit is 1.
        q1.push_back(mk(9'h37, 1'b1, 1'b0, 1'b0));
        send_frame(1, 9'h37, 8, 1, 1'b0, 2'b01, 1);
        pulse_clr(1);
        q1.push_back(mk(9'h37, 1'b0, 1'b0, 1'b0));
        send_frame(1, 9'h37, 8, 1, 1'b1, 2'b01, 1);
        pulse_clr(1);

        // 7 data bits, 2 stop bits: second stop low, then a clean frame.
        q2.push_back(mk(9'h55, 1'b0, 1'b1, 1'b0));
        send_frame(2, 9'h55, 7, 0, 1'b0, 2'b01, 2);
        pulse_clr(2);
        q2.push_back(mk(9'h2A, 1'b0, 1'b0, 1'b0));
        send_frame(2, 9'h2A, 7, 0, 1'b0, 2'b11, 2);
        pulse_clr(2);

        idle(50);
        check("u0 scoreboard drained", q0.size(), 32'd0);
        check("u1 scoreboard drained", q1.size(), 32'd0);
        check("u2 scoreboard drained", q2.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
